imem_responder: RTL

Synchronous instruction-memory responder serving the memory end of the fetch interface. It accepts the fetch stage's `imem_req`/`imem_addr`, reads a word-addressed storage array, and returns `imem_data` through a fixed-latency response pipeline with a valid strobe. A side load port lets the bench or boot logic write program words.

---
 rtl/imem_responder_if.sv | 19 +
 rtl/imem_responder.sv | 59 +++++
 2 files changed

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response and load-port signals of the instruction memory
interface imem_responder_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        imem_fault;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  modport master (
    output imem_req, imem_addr, load_we, load_addr, load_data,
    input  imem_data, imem_valid, imem_fault
  );
  modport slave (
    input  imem_req, imem_addr, load_we, load_addr, load_data,
    output imem_data, imem_valid, imem_fault
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction memory with a fixed-latency response pipeline; IMEM_FAULT_EN enables fault responses for misaligned/out-of-range fetches
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset_n,
  imem_responder_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  logic [31:0]                 mem_q [DEPTH_WORDS];
  logic [LATENCY-1:0]          v_q, f_q;
  logic [LATENCY-1:0][31:0]    d_q;
  logic [31:0]                 ld_off, rd_word, w_d;
  logic [AW-1:0]               rd_idx, ld_idx;
  logic                        ld_ok, fault_calc, f_d;
  // Address decode for both ports; a faulting fetch never touches the array
  always_comb begin
    rd_idx  = AW'((bus.imem_addr - BASE_ADDR) >> 2);
    ld_off  = bus.load_addr - BASE_ADDR;
    ld_idx  = AW'(ld_off >> 2);
    ld_ok   = ld_off < SPAN;
`ifdef IMEM_FAULT_EN
    fault_calc = (|bus.imem_addr[1:0]) || ((bus.imem_addr - BASE_ADDR) >= SPAN);
`else
    fault_calc = 1'b0;
`endif
    rd_word = fault_calc ? NOP : mem_q[rd_idx];
    f_d     = bus.imem_req & fault_calc;
    w_d     = bus.imem_req ? rd_word : d_q[0];
  end
  // Load port; the array has no reset so program words survive reset_n
  always_ff @(posedge clk) begin
    if (bus.load_we && ld_ok) mem_q[ld_idx] <= bus.load_data;
  end
  // Response pipeline; data only advances on a request so idle cycles keep the last word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      f_q <= '0;
      d_q <= {LATENCY{NOP}};
    end else begin
      v_q[0] <= bus.imem_req;
      f_q[0] <= f_d;
      d_q[0] <= w_d;
      for (int i = 1; i < LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end
  assign bus.imem_valid = v_q[LATENCY-1];
  assign bus.imem_fault = f_q[LATENCY-1];
  assign bus.imem_data  = d_q[LATENCY-1];
endmodule
